// File: rtl/veda_pkg.sv
// Shared VEDA core definitions: opcodes, PC sentinel, fetch FSM states.
package veda_pkg;

  localparam logic [5:0]  R_OP    = 6'b000000;
  localparam logic [5:0]  J_OP    = 6'b000010;
  localparam logic [5:0]  JAL_OP  = 6'b000011;
  localparam logic [5:0]  HALT_OP = 6'b111111;

  localparam logic [31:0] PC_INIT = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // A control-transfer target must be word aligned and inside instruction memory.
  function automatic logic target_invalid(input logic [31:0] target,
                                          input logic [31:0] mem_bytes);
    return (target[1:0] != 2'b00) || (target >= mem_bytes);
  endfunction

endpackage

// File: rtl/veda_fetch_if.sv
// Fetch-stage bundle: control inputs, imem word, execute redirect and fetch outputs.
interface veda_fetch_if;

  logic        start;
  logic        stall;
  logic [31:0] instr;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        addr_err;
  logic [31:0] fetch_count;

  modport master (
    input  start, stall, instr, redir_valid, redir_target,
    output pc, pc_plus4, fetch_valid, halted, addr_err, fetch_count
  );

  modport slave (
    output start, stall, instr, redir_valid, redir_target,
    input  pc, pc_plus4, fetch_valid, halted, addr_err, fetch_count
  );

endinterface

// File: rtl/veda_next_pc.sv
// Combinational next-PC selection for RUN: redirect > stall > halt > j/jal > sequential.
module veda_next_pc
  import veda_pkg::*;
#(
  parameter int unsigned IM_WORDS = 128
) (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        target_bad,
  output logic        halt_hit
);

  localparam logic [31:0] IM_BYTES = 32'(IM_WORDS * 4);
  localparam logic [31:0] LAST_PC  = IM_BYTES - 32'd4;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [5:0]  op;

  always_comb begin
    pc_plus4    = pc + 32'd4;
    op          = instr[31:26];
    jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    next_pc     = pc;
    target_bad  = 1'b0;
    halt_hit    = 1'b0;

    // The redirect squashes the current word, so its decode must not matter.
    if (redir_valid) begin
      next_pc    = redir_target;
      target_bad = target_invalid(redir_target, IM_BYTES);
    end else if (stall) begin
      next_pc = pc;
    end else if (op == HALT_OP) begin
      halt_hit = 1'b1;
    end else if (op == J_OP || op == JAL_OP) begin
      next_pc    = jump_target;
      target_bad = target_invalid(jump_target, IM_BYTES);
    end else begin
      next_pc = (pc == LAST_PC) ? '0 : pc_plus4;
    end
  end

endmodule

// File: rtl/veda_fetch.sv
// VEDA fetch stage: PC register, INIT/RUN/HALT control, issue counter, sticky address error.
module veda_fetch
  import veda_pkg::*;
#(
  parameter int unsigned IM_WORDS = 128
) (
  input  logic         clk,
  input  logic         rst,
  veda_fetch_if.master fif
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_q, pc_n;
  logic [31:0]  count_q, count_n;
  logic         err_q, err_n;

  logic [31:0]  sel_pc;
  logic         target_bad;
  logic         halt_hit;

  veda_next_pc #(
    .IM_WORDS (IM_WORDS)
  ) u_next_pc (
    .pc           (pc_q),
    .instr        (fif.instr),
    .redir_valid  (fif.redir_valid),
    .redir_target (fif.redir_target),
    .stall        (fif.stall),
    .next_pc      (sel_pc),
    .target_bad   (target_bad),
    .halt_hit     (halt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      pc_q    <= PC_INIT;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      count_q <= count_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    count_n = count_q;
    err_n   = err_q;
    unique case (state)
      INIT: begin
        if (fif.start) begin
          state_n = RUN;
          pc_n    = '0;
        end
      end
      RUN: begin
        // A bad jump target still counts its fetch; a redirect never does.
        if (!fif.redir_valid && !fif.stall) count_n = count_q + 32'd1;
        if (target_bad) begin
          state_n = HALT;
          err_n   = 1'b1;
        end else begin
          pc_n = sel_pc;
          if (halt_hit) state_n = HALT;
        end
      end
      HALT: begin
      end
      default: state_n = INIT;
    endcase
  end

  assign fif.pc          = pc_q;
  assign fif.pc_plus4    = pc_q + 32'd4;
  assign fif.fetch_valid = (state == RUN) && !fif.stall;
  assign fif.halted      = (state == HALT);
  assign fif.addr_err    = err_q;
  assign fif.fetch_count = count_q;

endmodule

// File: tb/tb_veda_fetch.sv
// Directed bench for veda_fetch: vector table for the main flow, hand sequences for errors and reset.
module tb_veda_fetch;

  localparam logic [31:0] ADDI  = 32'h2001_0001;
  localparam logic [31:0] J10   = 32'h0800_0010;
  localparam logic [31:0] JAL20 = 32'h0C00_0020;
  localparam logic [31:0] JOOR  = 32'h0800_0080;
  localparam logic [31:0] HWORD = 32'hFC00_0000;

  typedef struct {
    logic        start;
    logic        stall;
    logic [31:0] instr;
    logic        rv;
    logic [31:0] rt;
    logic [31:0] epc;
    logic        efv;
    logic        eh;
    logic        ee;
    logic [31:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [20];

  veda_fetch_if fif ();

  veda_fetch #(
    .IM_WORDS (128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic sl, input logic [31:0] ins,
                              input logic rv, input logic [31:0] rt, input logic [31:0] epc,
                              input logic efv, input logic eh, input logic ee,
                              input logic [31:0] ecnt);
    vec_t v;
    v.start = st; v.stall = sl; v.instr = ins; v.rv = rv; v.rt = rt;
    v.epc = epc; v.efv = efv; v.eh = eh; v.ee = ee; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] epc, input logic efv,
                       input logic eh, input logic ee, input logic [31:0] ecnt);
    cmp({tag, ".pc"},          fif.pc,                  epc);
    cmp({tag, ".pc_plus4"},    fif.pc_plus4,            epc + 32'd4);
    cmp({tag, ".fetch_valid"}, 32'(fif.fetch_valid),    32'(efv));
    cmp({tag, ".halted"},      32'(fif.halted),         32'(eh));
    cmp({tag, ".addr_err"},    32'(fif.addr_err),       32'(ee));
    cmp({tag, ".fetch_count"}, fif.fetch_count,         ecnt);
  endtask

  task automatic drive(input logic st, input logic sl, input logic [31:0] ins,
                       input logic rv, input logic [31:0] rt);
    fif.start        = st;
    fif.stall        = sl;
    fif.instr        = ins;
    fif.redir_valid  = rv;
    fif.redir_target = rt;
  endtask

  task automatic step(input logic st, input logic sl, input logic [31:0] ins,
                      input logic rv, input logic [31:0] rt);
    drive(st, sl, ins, rv, rt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, HWORD, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, HWORD, 0, 32'h0,   32'hFFFF_FFFC, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, HWORD, 0, 32'h0,   32'hFFFF_FFFC, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, HWORD, 0, 32'h0,   32'hFFFF_FFFC, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, HWORD, 0, 32'h0,   32'h0,   1, 0, 0, 0);
    vecs[4]  = mk(0, 0, ADDI,  0, 32'h0,   32'h4,   1, 0, 0, 1);
    vecs[5]  = mk(0, 1, J10,   0, 32'h0,   32'h4,   0, 0, 0, 1);
    vecs[6]  = mk(0, 1, J10,   0, 32'h0,   32'h4,   0, 0, 0, 1);
    vecs[7]  = mk(0, 0, J10,   0, 32'h0,   32'h40,  1, 0, 0, 2);
    vecs[8]  = mk(0, 1, J10,   1, 32'h20,  32'h20,  0, 0, 0, 2);
    vecs[9]  = mk(0, 0, JAL20, 0, 32'h0,   32'h80,  1, 0, 0, 3);
    vecs[10] = mk(0, 0, ADDI,  0, 32'h0,   32'h84,  1, 0, 0, 4);
    vecs[11] = mk(0, 0, HWORD, 1, 32'h1F8, 32'h1F8, 1, 0, 0, 4);
    vecs[12] = mk(0, 0, ADDI,  0, 32'h0,   32'h1FC, 1, 0, 0, 5);
    vecs[13] = mk(0, 0, ADDI,  0, 32'h0,   32'h0,   1, 0, 0, 6);
    vecs[14] = mk(0, 0, ADDI,  0, 32'h0,   32'h4,   1, 0, 0, 7);
    vecs[15] = mk(0, 0, ADDI,  0, 32'h0,   32'h8,   1, 0, 0, 8);
    vecs[16] = mk(0, 0, ADDI,  0, 32'h0,   32'hC,   1, 0, 0, 9);
    vecs[17] = mk(0, 0, HWORD, 0, 32'h0,   32'hC,   0, 1, 0, 10);
    vecs[18] = mk(1, 1, J10,   1, 32'h40,  32'hC,   0, 1, 0, 10);
    vecs[19] = mk(0, 0, ADDI,  0, 32'h0,   32'hC,   0, 1, 0, 10);

    drive(1'b0, 1'b0, HWORD, 1'b0, 32'h0);
    do_reset();
    check("reset", 32'hFFFF_FFFC, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].start, vecs[i].stall, vecs[i].instr, vecs[i].rv, vecs[i].rt);
      check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].efv, vecs[i].eh, vecs[i].ee, vecs[i].ecnt);
    end

    // Misaligned redirect, then reset clears the sticky error
    do_reset();
    step(1, 0, HWORD, 0, 32'h0);
    step(0, 0, ADDI,  0, 32'h0);
    check("mis.run", 32'h4, 1, 0, 0, 1);
    step(0, 0, ADDI,  1, 32'h202);
    check("mis.err", 32'h4, 0, 1, 1, 1);
    step(0, 0, ADDI,  1, 32'h8);
    check("mis.frozen", 32'h4, 0, 1, 1, 1);
    do_reset();
    check("mis.rst", 32'hFFFF_FFFC, 0, 0, 0, 0);

    // Redirect exactly one byte-word past the end of memory
    step(1, 0, HWORD, 0, 32'h0);
    step(0, 0, ADDI,  1, 32'h200);
    check("oor.redir", 32'h0, 0, 1, 1, 0);

    // Jump whose target lands at the memory size; the fetch itself is counted
    do_reset();
    step(1, 0, HWORD, 0, 32'h0);
    step(0, 0, JOOR,  0, 32'h0);
    check("oor.jump", 32'h0, 0, 1, 1, 1);

    // Reset mid-run at pc=0x10 overrides start
    do_reset();
    step(1, 0, HWORD, 0, 32'h0);
    for (int k = 0; k < 4; k++) step(0, 0, ADDI, 0, 32'h0);
    check("mid.run", 32'h10, 1, 0, 0, 4);
    rst = 1'b1;
    step(1, 0, ADDI, 0, 32'h0);
    rst = 1'b0;
    check("mid.rst", 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(0, 0, HWORD, 0, 32'h0);
    check("mid.idle", 32'hFFFF_FFFC, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
